// File: rtl/gpr_rob.sv
// gpr_rob: in-order reorder buffer for GPR results; ROB_CDB_BYPASS_EN forwards same-cycle CDB data to read/commit ports
module gpr_rob #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_WIDTH = 5,
    parameter int N_CDB     = 2,
    parameter int N_RD      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_req,
    input  logic [REG_WIDTH-1:0] alloc_arch,
    output logic                 alloc_ready,
    output logic [ROB_WIDTH-1:0] alloc_tag,
    input  logic [N_CDB-1:0]     cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_tag [N_CDB],
    input  logic [31:0]          cdb_data [N_CDB],
    input  logic [ROB_WIDTH-1:0] rd_tag [N_RD],
    output logic [N_RD-1:0]      rd_valid,
    output logic [31:0]          rd_data [N_RD],
    input  logic                 commit_en,
    output logic                 commit_valid,
    output logic [REG_WIDTH-1:0] commit_arch,
    output logic [31:0]          commit_data,
    output logic [ROB_WIDTH-1:0] commit_tag,
    input  logic                 flush
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;
    logic [DEPTH-1:0]     occ_q, occ_d, val_q, val_d;
    logic [REG_WIDTH-1:0] arch_q [DEPTH];
    logic [REG_WIDTH-1:0] arch_d [DEPTH];
    logic [31:0]          data_q [DEPTH];
    logic [31:0]          data_d [DEPTH];
    logic                 do_alloc, do_commit;

    assign alloc_ready = count_q != (ROB_WIDTH+1)'(DEPTH);
    assign alloc_tag   = tail_q;
    assign commit_arch = arch_q[head_q];
    assign commit_tag  = head_q;

    // Operand and head lookups from registered state, overlaid with same-cycle CDB results when bypass is built in
    always_comb begin
        for (int j = 0; j < N_RD; j++) begin
            rd_valid[j] = occ_q[rd_tag[j]] & val_q[rd_tag[j]];
            rd_data[j]  = data_q[rd_tag[j]];
`ifdef ROB_CDB_BYPASS_EN
            for (int i = N_CDB - 1; i >= 0; i--) begin
                if (cdb_valid[i] && cdb_tag[i] == rd_tag[j] && occ_q[rd_tag[j]]) begin
                    rd_valid[j] = 1'b1;
                    rd_data[j]  = cdb_data[i];
                end
            end
`endif
        end
        commit_valid = occ_q[head_q] & val_q[head_q];
        commit_data  = data_q[head_q];
`ifdef ROB_CDB_BYPASS_EN
        for (int i = N_CDB - 1; i >= 0; i--) begin
            if (cdb_valid[i] && cdb_tag[i] == head_q && occ_q[head_q]) begin
                commit_valid = 1'b1;
                commit_data  = cdb_data[i];
            end
        end
`endif
    end

    // Next state: CDB writes land only on occupied slots (lower CDB index wins), then commit frees head, alloc claims tail
    always_comb begin
        do_alloc  = alloc_req & alloc_ready;
        do_commit = commit_en & commit_valid;
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        val_d     = val_q;
        arch_d    = arch_q;
        data_d    = data_q;
        for (int i = N_CDB - 1; i >= 0; i--) begin
            if (cdb_valid[i] && occ_q[cdb_tag[i]]) begin
                val_d[cdb_tag[i]]  = 1'b1;
                data_d[cdb_tag[i]] = cdb_data[i];
            end
        end
        if (do_commit) begin
            occ_d[head_q] = 1'b0;
            head_d        = head_q + 1'b1;
        end
        if (do_alloc) begin
            occ_d[tail_q]  = 1'b1;
            val_d[tail_q]  = 1'b0;
            arch_d[tail_q] = alloc_arch;
            tail_d         = tail_q + 1'b1;
        end
        count_d = count_q + (ROB_WIDTH+1)'(do_alloc) - (ROB_WIDTH+1)'(do_commit);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            occ_d   = '0;
            val_d   = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            occ_q   <= '0;
            val_q   <= '0;
            arch_q  <= '{default: '0};
            data_q  <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            occ_q   <= occ_d;
            val_q   <= val_d;
            arch_q  <= arch_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_gpr_rob.sv
// tb_gpr_rob: directed + random bench for gpr_rob against a queue-based program-order model
module tb_gpr_rob;
    logic        clk = 1'b0;
    logic        reset, alloc_req, commit_en, flush;
    logic [4:0]  alloc_arch;
    logic        alloc_ready, commit_valid;
    logic [3:0]  alloc_tag, commit_tag;
    logic [1:0]  cdb_valid;
    logic [3:0]  cdb_tag [2];
    logic [31:0] cdb_data [2];
    logic [3:0]  rd_tag [2];
    logic [1:0]  rd_valid;
    logic [31:0] rd_data [2];
    logic [4:0]  commit_arch;
    logic [31:0] commit_data;

    gpr_rob dut (
        .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_arch(alloc_arch),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .rd_tag(rd_tag), .rd_valid(rd_valid),
        .rd_data(rd_data), .commit_en(commit_en), .commit_valid(commit_valid),
        .commit_arch(commit_arch), .commit_data(commit_data), .commit_tag(commit_tag),
        .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [4:0]  arch;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   head, tail;
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int find(input int t);
        foreach (q[k]) if (q[k].tag == t) return k;
        return -1;
    endfunction

    function automatic logic [3:0] pick_tag();
        if (q.size() > 0 && $urandom_range(0, 3) != 0) return 4'(q[$urandom_range(0, q.size() - 1)].tag);
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic model_update(input bit a, input logic [4:0] ar, input bit v0, input logic [3:0] t0,
                                input logic [31:0] d0, input bit v1, input logic [3:0] t1,
                                input logic [31:0] d1, input bit ce, input bit fl);
        bit can_a, can_c;
        int k;
        if (fl) begin
            q.delete();
            head = 0;
            tail = 0;
            return;
        end
        can_a = q.size() < 16;
        can_c = q.size() > 0 && q[0].done;
        if (v1) begin
            k = find(int'(t1));
            if (k >= 0) begin q[k].done = 1; q[k].data = d1; end
        end
        if (v0) begin
            k = find(int'(t0));
            if (k >= 0) begin q[k].done = 1; q[k].data = d0; end
        end
`ifdef ROB_CDB_BYPASS_EN
        can_c = q.size() > 0 && q[0].done;
`endif
        if (ce && can_c) begin
            void'(q.pop_front());
            head = (head + 1) % 16;
        end
        if (a && can_a) begin
            q.push_back('{tag: tail, arch: ar, done: 0, data: 0});
            tail = (tail + 1) % 16;
        end
    endtask

    task automatic check_outs();
        bit ecv, erv;
        int k;
        chk("alloc_ready", alloc_ready, q.size() < 16);
        chk("alloc_tag", alloc_tag, tail);
        chk("commit_tag", commit_tag, head);
        ecv = q.size() > 0 && q[0].done;
        chk("commit_valid", commit_valid, ecv);
        if (ecv) begin
            chk("commit_arch", commit_arch, q[0].arch);
            chk("commit_data", commit_data, q[0].data);
        end
        for (int j = 0; j < 2; j++) begin
            k = find(int'(rd_tag[j]));
            erv = k >= 0 && q[k].done;
            chk("rd_valid", rd_valid[j], erv);
            if (erv) chk("rd_data", rd_data[j], q[k].data);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        alloc_req    = 0;
        commit_en    = 0;
        flush        = 0;
        cdb_valid    = '0;
        rd_tag[0]    = 4'($urandom_range(0, 15));
        rd_tag[1]    = 4'($urandom_range(0, 15));
        #1;
        check_outs();
    endtask

    task automatic drive(input bit a, input logic [4:0] ar, input bit v0, input logic [3:0] t0,
                         input logic [31:0] d0, input bit v1, input logic [3:0] t1,
                         input logic [31:0] d1, input bit ce, input bit fl);
        alloc_req    = a;
        alloc_arch   = ar;
        cdb_valid    = {v1, v0};
        cdb_tag[0]   = t0;
        cdb_data[0]  = d0;
        cdb_tag[1]   = t1;
        cdb_data[1]  = d1;
        commit_en    = ce;
        flush        = fl;
        @(posedge clk);
        model_update(a, ar, v0, t0, d0, v1, t1, d1, ce, fl);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1;
        alloc_req = 0; alloc_arch = 0; commit_en = 0; flush = 0; cdb_valid = '0;
        cdb_tag[0] = 0; cdb_tag[1] = 0; cdb_data[0] = 0; cdb_data[1] = 0;
        rd_tag[0] = 0; rd_tag[1] = 0;
        repeat (2) @(posedge clk);
        q.delete();
        head = 0;
        tail = 0;
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        logic [3:0] t;
        reset_dut();
        settle();
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_rd_valid", rd_valid, 0);
        for (int i = 1; i <= 16; i++) begin
            settle();
            chk("fill_tag", alloc_tag, i - 1);
            drive(1, 5'(i), 0, 0, 0, 0, 0, 0, 0, 0);
        end
        settle();
        chk("full_ready", alloc_ready, 0);
        drive(1, 5'd17, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("full_tag_held", alloc_tag, 0);
        drive(0, 0, 1, 4'd0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        settle();
        chk("cdb_commit_valid", commit_valid, 1);
        chk("cdb_commit_arch", commit_arch, 1);
        chk("cdb_commit_data", commit_data, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        chk("commit_head", commit_tag, 1);
        drive(1, 5'd20, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("refull_ready", alloc_ready, 0);
        drive(0, 0, 0, 0, 0, 1, 4'd1, 32'h123, 0, 0);
        settle();
        drive(1, 5'd21, 0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        chk("full_ac_ready", alloc_ready, 1);
        chk("full_ac_head", commit_tag, 2);
        chk("full_ac_tail", alloc_tag, 1);
        reset_dut();
        for (int i = 0; i < 20; i++) begin
            settle();
            t = alloc_tag;
            drive(1, 5'($urandom), 0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            drive(0, 0, 1, 4'(tail == 0 ? 15 : tail - 1), $urandom, 0, 0, 0, 0, 0);
            settle();
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        settle();
        chk("wrap_tag", alloc_tag, 4);
        drive(0, 0, 1, 4'd3, 32'hBAD, 0, 0, 0, 0, 0);
        settle();
        rd_tag[0] = 4'd3;
        #1;
        chk("wrap_rd3", rd_valid[0], 0);
        chk("wrap_cv", commit_valid, 0);
        chk("wrap_tag2", alloc_tag, 4);
        for (int i = 0; i < 5; i++) begin
            settle();
            drive(1, 5'(i), 0, 0, 0, 0, 0, 0, 0, 0);
        end
        settle();
        drive(0, 0, 1, 4'd4, 32'h77, 0, 0, 0, 0, 0);
        settle();
        drive(1, 5'd9, 1, 4'd5, 32'h88, 0, 0, 0, 1, 1);
        settle();
        chk("flush_cv", commit_valid, 0);
        chk("flush_head", commit_tag, 0);
        chk("flush_tail", alloc_tag, 0);
        chk("flush_ready", alloc_ready, 1);
`ifdef ROB_CDB_BYPASS_EN
        for (int i = 0; i < 3; i++) begin
            settle();
            drive(1, 5'(i), 0, 0, 0, 0, 0, 0, 0, 0);
        end
        settle();
        rd_tag[0] = 4'd2;
        cdb_valid = 2'b10;
        cdb_tag[1] = 4'd2;
        cdb_data[1] = 32'h5;
        #1;
        chk("byp_rd_valid", rd_valid[0], 1);
        chk("byp_rd_data", rd_data[0], 32'h5);
        drive(0, 0, 0, 0, 0, 1, 4'd2, 32'h5, 0, 0);
`endif
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            settle();
            drive($urandom_range(0, 99) < 60, 5'($urandom), $urandom_range(0, 1) == 1, pick_tag(), $urandom,
                  $urandom_range(0, 2) == 0, pick_tag(), $urandom, $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) == 0);
        end
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
